log_reader: RTL

- Read-side companion to the violation logger: drains the 37-bit violation log RAM through its read port (re/rd_addr/rd_data) and streams each entry to a debug consumer over a valid/ready interface.
- Snoops logger write strobes to know how many entries exist, so the logger needs no changes.
- Sits beside the log RAM in the vrased wrapper; its outputs drive the RAM read port that is currently tied off.

---
 rtl/log_reader_pkg.sv | 16 +
 rtl/log_reader_if.sv | 36 +++
 rtl/log_entry_counter.sv | 31 +++
 rtl/log_reader.sv | 107 ++++++++++
 4 files changed

// File: rtl/log_reader_pkg.sv
// Shared widths and FSM state type for the violation log reader.
// Optional macro LOG_READER_PARITY_EN adds an even-parity output.
package log_reader_pkg;

  localparam int unsigned LOG_ENTRY_W = 37;
  localparam int unsigned LOG_ADDR_W  = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAP  = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/log_reader_if.sv
// Log RAM read port plus the outgoing entry stream.
// master: log_reader side; slave: RAM / debug consumer side.
// Optional macro LOG_READER_PARITY_EN adds out_parity.
interface log_reader_if import log_reader_pkg::*; #(
  parameter int unsigned ENTRY_W = LOG_ENTRY_W,
  parameter int unsigned ADDR_W  = LOG_ADDR_W
) ();

  logic               re;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  logic               out_valid;
  logic               out_ready;
  logic [ENTRY_W-1:0] out_data;
  logic               out_last;
`ifdef LOG_READER_PARITY_EN
  logic               out_parity;
`endif

  modport master (
`ifdef LOG_READER_PARITY_EN
    output out_parity,
`endif
    output re, rd_addr, out_valid, out_data, out_last,
    input  rd_data, out_ready
  );

  modport slave (
`ifdef LOG_READER_PARITY_EN
    input  out_parity,
`endif
    input  re, rd_addr, out_valid, out_data, out_last,
    output rd_data, out_ready
  );

endinterface

// File: rtl/log_entry_counter.sv
// Counts snooped logger writes, saturating at LOG_DEPTH with a sticky
// overflow flag; clr_ram clears both and wins over a coincident write.
module log_entry_counter import log_reader_pkg::*; #(
  parameter  int unsigned LOG_DEPTH = 1024,
  localparam int unsigned CNT_W     = $clog2(LOG_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             log_we,
  input  logic             clr_ram,
  output logic [CNT_W-1:0] entry_cnt,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LOG_DEPTH);

  // Saturating entry count and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_cnt <= '0;
      overflow  <= 1'b0;
    end else if (clr_ram) begin
      entry_cnt <= '0;
      overflow  <= 1'b0;
    end else if (log_we) begin
      if (entry_cnt < DEPTH_C) entry_cnt <= entry_cnt + 1'b1;
      else                     overflow  <= 1'b1;
    end
  end

endmodule

// File: rtl/log_reader.sv
// Drains the violation log RAM and streams each entry over valid/ready.
// A dump reads one entry per READ/CAP/SEND round; dump length is a
// snapshot of the entry count taken at start.
// Optional macro LOG_READER_PARITY_EN adds out_parity captured with out_data.
module log_reader import log_reader_pkg::*; #(
  parameter  int unsigned LOG_DEPTH = 1024,
  parameter  int unsigned ENTRY_W   = LOG_ENTRY_W,
  parameter  int unsigned ADDR_W    = LOG_ADDR_W,
  localparam int unsigned CNT_W     = $clog2(LOG_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           log_we,
  input  logic           clr_ram,
  input  logic           start,
  log_reader_if.master   bus,
  output logic           busy,
  output logic           done,
  output logic           overflow
);

  state_t             state, state_n;
  logic [CNT_W-1:0]   entry_cnt;
  logic [CNT_W-1:0]   dump_len;
  logic [CNT_W-1:0]   rd_ptr;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [ENTRY_W-1:0] out_data_q;
  logic               out_last_q;

  log_entry_counter #(.LOG_DEPTH(LOG_DEPTH)) u_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .log_we    (log_we),
    .clr_ram   (clr_ram),
    .entry_cnt (entry_cnt),
    .overflow  (overflow)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state logic; clr_ram aborts any dump back to IDLE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (entry_cnt != '0) ? READ : FIN;
      READ:    state_n = CAP;
      CAP:     state_n = SEND;
      SEND:    if (bus.out_ready) state_n = out_last_q ? FIN : READ;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clr_ram) state_n = IDLE;
  end

  // Dump pointer/length, read address and captured entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dump_len   <= '0;
      rd_ptr     <= '0;
      rd_addr_q  <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else if (!clr_ram) begin
      case (state)
        IDLE: if (start && entry_cnt != '0) begin
          dump_len  <= entry_cnt;
          rd_ptr    <= '0;
          rd_addr_q <= '0;
        end
        CAP: begin
          out_data_q <= bus.rd_data;
          out_last_q <= (rd_ptr == dump_len - 1'b1);
        end
        SEND: if (bus.out_ready && !out_last_q) begin
          rd_ptr    <= rd_ptr + 1'b1;
          rd_addr_q <= ADDR_W'(rd_ptr + 1'b1);
        end
        default: ;
      endcase
    end
  end

`ifdef LOG_READER_PARITY_EN
  logic out_parity_q;

  // Even parity of the entry, captured alongside out_data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      out_parity_q <= 1'b0;
    else if (!clr_ram && state == CAP) out_parity_q <= ^bus.rd_data;
  end

  assign bus.out_parity = out_parity_q;
`endif

  assign bus.re        = (state == READ);
  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_valid = (state == SEND);
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);

endmodule
